// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and types for the instruction fetch stage.
//
// Contents:
//   INSTR_W / OPCODE_W / OPCODE_LSB  instruction word and opcode field geometry
//   PC_STEP                          sequential fetch increment
//   DEFAULT_DEPTH / DEFAULT_MAX_OUTST default queue depth and request credit
//   fetchEntry_t                     one buffered instruction {pc, instr}
package fetch_queue_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned OPCODE_LSB = 0;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam int unsigned DEFAULT_DEPTH     = 4;
    localparam int unsigned DEFAULT_MAX_OUTST = 2;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: small synchronous FIFO used for the instruction queue and
// for the in-flight PC shadow of the fetch stage.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   push, pushData    write one entry (ignored when full unless popping too)
//   pop               remove the head entry (ignored when empty)
//   clear             synchronous flush; overrides push and pop that cycle
//   headData          current head entry (storage is zeroed by reset)
//   full, empty       occupancy flags
//   count             number of valid entries
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           headData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPop    = pop && !empty && !clear;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign doPush   = push && (!full || doPop) && !clear;
    assign headData = mem[rdPtr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= (wrPtr == LAST) ? '0 : wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= (rdPtr == LAST) ? '0 : rdPtr + AW'(1);
            end
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Issues sequential word-aligned fetches
// to instruction memory, buffers returned words in an in-order queue and hands
// them to ID under a valid/ready handshake. Redirects from EX flush the queue
// and mark every still-outstanding request as stale so its response is dropped.
//
// Optional feature: define FETCH_BYPASS_EN to let a response reach ID in the
// cycle it arrives when nothing is buffered ahead of it.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   imem_req, imem_addr          fetch request and its word address
//   imem_ready                   memory accepts the request this cycle
//   imem_rvalid, imem_rdata      in-order response from memory
//   redirect_valid, redirect_pc  control-flow change from EX
//   id_valid, id_ready           handshake towards the decoder
//   id_instr, id_pc, id_opcode   instruction word, its address, opcode field
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned MAX_OUTST = DEFAULT_MAX_OUTST,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [31:0]         id_pc,
    output logic [OPCODE_W-1:0] id_opcode
);

    localparam int unsigned QCW = $clog2(DEPTH + 1);
    localparam int unsigned SCW = $clog2(MAX_OUTST + 1);
    localparam int unsigned OCW = $clog2(MAX_OUTST + 1);

    // Fetch state
    logic [31:0]    fetchPc;
    logic [OCW-1:0] outst;
    logic [OCW-1:0] dropCnt;
    logic [OCW-1:0] outstAfterResp;
    logic [OCW-1:0] outstNext;

    // Control
    logic issued;
    logic creditOk;
    logic respKeep;
    logic bypass;

    // Instruction queue
    logic            qPush;
    logic            qPop;
    logic            qEmpty;
    logic [QCW-1:0]  qCount;
    fetchEntry_t     qIn;
    fetchEntry_t     qHead;

    // PC shadow of in-flight requests
    logic [31:0]     sHead;

    logic            unusedQFull;
    logic            unusedSFull;
    logic            unusedSEmpty;
    logic [SCW-1:0]  unusedSCount;
    logic [1:0]      unusedPcLsb;

    assign unusedPcLsb = redirect_pc[1:0];

    // Buffered plus in-flight words never exceed the queue, so every response
    // always has a slot waiting for it.
    assign creditOk = ((32'(qCount) + 32'(outst)) < DEPTH) && (32'(outst) < MAX_OUTST);

    // Gated by the reset level so the request drops the moment reset asserts.
    assign imem_req  = reset && !redirect_valid && creditOk;
    assign imem_addr = fetchPc;
    assign issued    = imem_req && imem_ready;

    assign respKeep = imem_rvalid && (dropCnt == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass = respKeep && qEmpty;
    assign qPush  = respKeep && !(bypass && id_ready);
`else
    assign bypass = 1'b0;
    assign qPush  = respKeep;
`endif

    assign qIn.pc    = sHead;
    assign qIn.instr = imem_rdata;

    assign id_valid  = reset && !redirect_valid && (!qEmpty || bypass);
    assign id_instr  = bypass ? imem_rdata : qHead.instr;
    assign id_pc     = bypass ? sHead : qHead.pc;
    assign id_opcode = id_instr[OPCODE_LSB +: OPCODE_W];

    // A bypassed word never occupies the queue, so only buffered heads pop.
    assign qPop = id_valid && id_ready && !qEmpty;

    assign outstAfterResp = outst - OCW'(imem_rvalid);
    assign outstNext      = outstAfterResp + OCW'(issued);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchPc <= RESET_PC;
            outst   <= '0;
            dropCnt <= '0;
        end else begin
            outst <= outstNext;
            if (redirect_valid) begin
                fetchPc <= {redirect_pc[31:2], 2'b00};
                // Everything still in flight after this cycle's response is stale.
                dropCnt <= outstAfterResp;
            end else begin
                if (issued) begin
                    fetchPc <= fetchPc + PC_STEP;
                end
                if (imem_rvalid && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - OCW'(1);
                end
            end
        end
    end

    fetch_queue_fifo #(
        .WIDTH ($bits(fetchEntry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (qPush),
        .pushData (qIn),
        .pop      (qPop),
        .clear    (redirect_valid),
        .headData (qHead),
        .full     (unusedQFull),
        .empty    (qEmpty),
        .count    (qCount)
    );

    // Not cleared on redirect: stale requests are still owed a response.
    fetch_queue_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTST)
    ) u_pc_shadow (
        .clock    (clock),
        .reset    (reset),
        .push     (issued),
        .pushData (fetchPc),
        .pop      (imem_rvalid),
        .clear    (1'b0),
        .headData (sHead),
        .full     (unusedSFull),
        .empty    (unusedSEmpty),
        .count    (unusedSCount)
    );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    int checks = 0;
    int errors = 0;

    logic [31:0] expq [$];
    logic [31:0] pend [$];
    bit          memStall = 0;

`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    fetch_queue #(
        .DEPTH     (4),
        .MAX_OUTST (2),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold id_ready high until n handshakes have happened (bounded).
    task automatic consume(input int n, input bit keep, output int cyc);
        int got = 0;
        cyc = 0;
        id_ready = 1;
        while (got < n && cyc < 100) begin
            @(negedge clock);
            if (id_valid === 1'b1) got++;
            cyc++;
            @(posedge clock);
            #1;
        end
        if (!keep) id_ready = 0;
        check32("consume_count", 32'(got), 32'(n));
    endtask

    // Memory: records accepted requests mid-cycle, answers one per cycle in order.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && imem_req === 1'b1 && imem_ready === 1'b1)
                pend.push_back(imem_addr);
        end
    end

    initial begin
        imem_rvalid = 0;
        imem_rdata  = 0;
        forever begin
            @(posedge clock);
            #2;
            if (reset === 1'b1 && !memStall && pend.size() > 0) begin
                imem_rvalid = 1;
                imem_rdata  = memWord(pend.pop_front());
            end else begin
                imem_rvalid = 0;
            end
        end
    end

    // Scoreboard monitor: every handshake must match the next expected PC.
    initial begin
        logic [31:0] e;
        logic [31:0] w;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop actual pc %h expected none", id_pc);
                end else begin
                    e = expq.pop_front();
                    w = memWord(e);
                    check32("id_pc", id_pc, e);
                    check32("id_instr", id_instr, w);
                    check32("id_opcode", 32'(id_opcode), 32'(w[6:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset          = 1;
        id_ready       = 1;
        imem_ready     = 1;
        redirect_valid = 0;
        redirect_pc    = 0;
        #1 reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkBit("rst_imem_req", imem_req, 1'b0);
        checkBit("rst_id_valid", id_valid, 1'b0);
        check32("rst_id_instr", id_instr, 32'h0);
        check32("rst_id_pc", id_pc, 32'h0);
        check32("rst_id_opcode", 32'(id_opcode), 32'h0);

        // Streaming from reset: PCs 0,4,8,12 on consecutive cycles.
        tick();
        reset = 1;
        for (int i = 0; i < 4; i++) expq.push_back(32'(4 * i));
        for (int c = 0; c < FIRST_VALID + 4; c++) begin
            @(negedge clock);
            if (c == 0) begin
                checkBit("first_req", imem_req, 1'b1);
                check32("first_addr", imem_addr, 32'h0);
            end
            checkBit("valid_timing", id_valid, c >= FIRST_VALID);
            tick();
        end
        id_ready = 0;

        // Stall: queue fills, request drops, outputs hold.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i >= 4) begin
                checkBit("stall_req", imem_req, 1'b0);
                checkBit("stall_valid", id_valid, 1'b1);
                check32("stall_pc", id_pc, 32'd16);
                check32("stall_instr", id_instr, memWord(32'd16));
            end
            tick();
        end
        for (int i = 4; i < 8; i++) expq.push_back(32'(4 * i));
        consume(4, 0, cyc);
        check32("drain_cycles", 32'(cyc), 32'd4);
        repeat (6) tick();

        // Redirect with a full queue, then with two stalled requests in flight.
        memStall       = 1;
        redirect_valid = 1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clock);
        checkBit("redir1_valid", id_valid, 1'b0);
        checkBit("redir1_req", imem_req, 1'b0);
        tick();
        redirect_valid = 0;
        @(negedge clock);
        checkBit("redir1_req_a", imem_req, 1'b1);
        check32("redir1_addr_a", imem_addr, 32'h0000_0200);
        tick();
        @(negedge clock);
        checkBit("redir1_req_b", imem_req, 1'b1);
        check32("redir1_addr_b", imem_addr, 32'h0000_0204);
        tick();
        @(negedge clock);
        checkBit("outst_limit_req", imem_req, 1'b0);
        checkBit("flushed_valid", id_valid, 1'b0);
        tick();
        redirect_valid = 1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clock);
        checkBit("redir2_valid", id_valid, 1'b0);
        checkBit("redir2_req", imem_req, 1'b0);
        tick();
        redirect_valid = 0;
        memStall       = 0;
        expq.push_back(32'h0000_0100);
        expq.push_back(32'h0000_0104);
        expq.push_back(32'h0000_0108);
        consume(3, 1, cyc);

        // Redirect during steady streaming (pop and response in the same cycle).
        redirect_valid = 1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clock);
        checkBit("redir3_valid", id_valid, 1'b0);
        checkBit("redir3_req", imem_req, 1'b0);
        checkBit("steady_issue", imem_rvalid, 1'b1);
        tick();
        redirect_valid = 0;
        @(negedge clock);
        checkBit("redir3_req_a", imem_req, 1'b1);
        check32("redir3_addr_a", imem_addr, 32'hFFFF_FFF8);
        expq.push_back(32'hFFFF_FFF8);
        expq.push_back(32'hFFFF_FFFC);
        expq.push_back(32'h0000_0000);
        expq.push_back(32'h0000_0004);
        consume(4, 0, cyc);
        repeat (6) tick();

        // Reset with three entries buffered.
        memStall = 1;
        expq.push_back(32'h0000_0008);
        consume(1, 0, cyc);
        checkBit("pre_reset_valid", id_valid, 1'b1);
        check32("pre_reset_pc", id_pc, 32'h0000_000C);
        reset = 0;
        expq.delete();
        pend.delete();
        @(negedge clock);
        checkBit("reset_valid", id_valid, 1'b0);
        checkBit("reset_req", imem_req, 1'b0);
        tick();
        tick();
        @(negedge clock);
        check32("reset2_pc", id_pc, 32'h0);
        check32("reset2_instr", id_instr, 32'h0);
        tick();
        memStall = 0;
        reset    = 1;
        expq.push_back(32'h0000_0000);
        expq.push_back(32'h0000_0004);
        expq.push_back(32'h0000_0008);
        @(negedge clock);
        checkBit("restart_req", imem_req, 1'b1);
        check32("restart_addr", imem_addr, 32'h0);
        consume(3, 0, cyc);
        repeat (5) tick();
        check32("scoreboard_left", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
